seq_alu: RTL

Parametrised multi-cycle ALU that succeeds the combinational datapath ALU. It adds signed and unsigned multiply and divide, computed by iterative shift-add and restoring algorithms, and uses a start/done handshake so the control unit can stall on long operations. Results go to a 2×WIDTH HI/LO pair that feeds the HI/LO registers and the Z-register path. Add, sub and logic operations complete in one cycle.

---
 rtl/seq_alu.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with shift-add multiply, restoring divide and a start/done handshake.
// Define SEQ_ALU_DIV_EN to build the divider; without it ops 4/5 complete as reserved ops.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c_hi,
  output logic [WIDTH-1:0] c_lo,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // ITER  | one shift-add / restoring-subtract step per cycle
  // FIX   | sign correction, results registered
  // DONE  | done pulse; a new start is accepted here too
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULU = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
`endif

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_r, lo_r, opd;
  logic               neg_q;
  logic               op_signed, sc_multi;
  logic [WIDTH-1:0]   abs_a, abs_b, sc_hi, sc_lo;
  logic [WIDTH:0]     wide;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef SEQ_ALU_DIV_EN
  logic               is_div, neg_r, sc_dbz;
  logic [WIDTH:0]     div_shift, div_diff;
`endif

  // Single-cycle results and operand magnitudes for the iterative ops
  always_comb begin
    op_signed = (op == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
    op_signed = op_signed || (op == OP_DIV);
    sc_dbz    = 1'b0;
`endif
    abs_a    = (op_signed && a[WIDTH-1]) ? -a : a;
    abs_b    = (op_signed && b[WIDTH-1]) ? -b : b;
    wide     = '0;
    sc_hi    = '0;
    sc_lo    = '0;
    sc_multi = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        sc_lo = wide[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, wide[WIDTH]};
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        sc_lo = wide[WIDTH-1:0];
        sc_hi = {{(WIDTH-1){1'b0}}, wide[WIDTH]};
      end
      OP_MULU, OP_MUL: sc_multi = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU, OP_DIV: begin
        if (b == '0) begin
          sc_lo  = '1;
          sc_hi  = a;
          sc_dbz = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
`endif
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      default: ;
    endcase
  end

  assign mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd} : '0);
  assign prod_neg = -{hi_r, lo_r};
`ifdef SEQ_ALU_DIV_EN
  // div_diff[WIDTH] is set exactly when the shifted remainder is below the divisor
  assign div_shift = {hi_r, lo_r[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      opd   <= '0;
      neg_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c_hi  <= '0;
      c_lo  <= '0;
`ifdef SEQ_ALU_DIV_EN
      is_div      <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (sc_multi) begin
              state <= ITER;
              busy  <= 1'b1;
              count <= CW'(WIDTH);
              hi_r  <= '0;
              lo_r  <= abs_a;
              opd   <= abs_b;
              neg_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
              is_div <= (op == OP_DIVU) || (op == OP_DIV);
              neg_r  <= op_signed && a[WIDTH-1];
`endif
            end else begin
              state <= DONE;
              done  <= 1'b1;
              c_hi  <= sc_hi;
              c_lo  <= sc_lo;
`ifdef SEQ_ALU_DIV_EN
              div_by_zero <= sc_dbz;
`endif
            end
          end
        end
        ITER: begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
`ifdef SEQ_ALU_DIV_EN
          if (is_div) begin
            if (div_diff[WIDTH]) hi_r <= div_shift[WIDTH-1:0];
            else                 hi_r <= div_diff[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
`else
          begin
`endif
            hi_r <= mul_sum[WIDTH:1];
            lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
          div_by_zero <= 1'b0;
          if (is_div) begin
            c_lo <= neg_q ? -lo_r : lo_r;
            c_hi <= neg_r ? -hi_r : hi_r;
          end else begin
`else
          begin
`endif
            {c_hi, c_lo} <= neg_q ? prod_neg : {hi_r, lo_r};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_ALU_DIV_EN
  assign div_by_zero = 1'b0;
`endif

endmodule
